pc_predict_unit: RTL
====================

# pc_predict_unit

Parametrised successor to the fetch-stage PC register. It holds the program counter and selects the next fetch address from reset, EX-stage misprediction recovery, decode-stage jump, BTB-predicted taken branch, or sequential PC+4. A direct-mapped branch target buffer (BTB) with 2-bit saturating counters replaces the single static predict bit. Mispredictions are detected and a flush is raised here, and branch and mispredict counts are kept.

## Interface
Parameters:
- XLEN, 32, address/PC width
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pc_write  in  1  1 = PC may advance; 0 = hold (hazard stall)
- id_jump  in  1  decode stage holds a J-type (opcode 6'b000010)
- id_jump_target  in  XLEN  jump target from decode
- ex_valid  in  1  EX stage holds a valid resolved branch (opcode 6'b000100)
- ex_pc  in  XLEN  PC of the resolving branch
- ex_taken  in  1  branch outcome (zero & Branch)
- ex_target  in  XLEN  computed branch target
- ex_pred_taken  in  1  prediction carried down the pipe with this branch
- ex_pred_target  in  XLEN  predicted target carried with this branch
- pcvalue  out  XLEN  current fetch PC (registered)
- pred_taken  out  1  BTB predicts current pcvalue is a taken branch
- pred_target  out  XLEN  predicted target for current pcvalue
- flush  out  1  misprediction this cycle; IF/ID younger stages must be squashed
- branch_count  out  32  resolved branches since reset, saturating
- mispredict_count  out  32  mispredictions since reset, saturating

## Operation
- BTB entry fields: valid, tag = pc[XLEN-1:IDX+2], target, ctr[1:0]; IDX = log2(BTB_ENTRIES); index = pc[IDX+1:2].
- Lookup is combinational on pcvalue:
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = entry target; it is all zeros on a miss.
- Mispredict:
  - mispredict = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
  - flush = mispredict.
- Next-PC priority:
  1. reset → RESET_PC
  2. mispredict → (ex_taken ? ex_target : ex_pc+4), applied **regardless of pc_write**
  3. pc_write=0 → hold
  4. id_jump → id_jump_target
  5. pred_taken → pred_target
  6. otherwise pcvalue+4 (mod 2^XLEN)
- BTB update on ex_valid, independent of pc_write:
  - Hit, taken: ctr saturates up to 2'b11; target is overwritten with ex_target.
  - Hit, not taken: ctr saturates down to 2'b00.
  - Miss, taken: allocate the entry (overwriting any tag) with valid=1, ctr=2'b10, target=ex_target.
  - Miss, not taken: no change.
- Counters: branch_count increments on ex_valid; mispredict_count increments on mispredict. Both hold at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - pcvalue=RESET_PC.
  - All BTB valid=0 and ctr=2'b01.
  - branch_count=mispredict_count=0.
  - flush=0 while reset is high, even if ex_valid is set.
- flush is combinational in the resolving cycle; the redirected PC appears on pcvalue after the next rising edge (1-cycle redirect latency).
- Prediction has zero-cycle latency: pred_taken/pred_target are valid in the same cycle as pcvalue.
- Read-before-write: when an update and a lookup hit the same index in one cycle, the lookup sees the pre-update entry. The update is visible from the next cycle.
- Simultaneous mispredict and id_jump: mispredict wins, and the jump is discarded (it is on the squashed path).
- Reset asserted mid-operation overrides everything on that edge. In-flight updates are dropped.
- PC wrap: 32'hFFFF_FFFC + 4 → 32'h0000_0000 (XLEN=32).

## Structure
- Shared package pc_pkg:
  - OP_BEQ = 6'b000100, OP_J = 6'b000010.
  - Counter encodings SNT/WNT/WT/ST = 00/01/10/11.
  - Saturating-counter next-state function.
- Sub-module pc_btb (parameters XLEN, BTB_ENTRIES) holds the table: one combinational read port, one synchronous update port, and reset clear.
- Next-PC mux, mispredict detect, and statistics counters live in pc_predict_unit.

## Test plan
- Reset, then 4 cycles with pc_write=1 and no branches: pcvalue sequence 0, 4, 8, 12. flush=0 and pred_taken=0 throughout.
- Branch resolve: ex_valid=1, ex_pc=0x40, ex_taken=1, ex_target=0x100, ex_pred_taken=0.
  - Same cycle: flush=1.
  - Next edge: pcvalue=0x100, mispredict_count=1.
  - Next fetch of 0x40: pred_taken=1, pred_target=0x100.
- Counter saturation: resolve the branch at 0x40 taken twice more (ctr reaches 11), then not-taken once (ctr 10).
  - pred_taken stays 1.
  - A second not-taken drops ctr to 01, and pred_taken=0.
- pc_write=0 held for 3 cycles with id_jump=1: pcvalue holds. A mispredict in cycle 2 still redirects pcvalue to ex_pc+4 on that edge.
- Aliasing: BTB_ENTRIES=16; allocate 0x40 then 0x80 (same index, different tag).
  - Lookup of 0x40 misses.
  - Same-cycle update/lookup of 0x80 returns the old entry.
- Simultaneous mispredict and id_jump → mispredict target loaded. branch_count forced to 32'hFFFF_FFFF, plus one more branch → it stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared opcodes, branch-counter encodings and the 2-bit saturating counter update
// for the fetch-stage PC/prediction unit.
package pc_pkg;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = ctr_e'(cur + 2'b01);
    end else begin
      if (cur != SNT) nxt = ctr_e'(cur - 2'b01);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup port, synchronous
// update port; lookups see the pre-update entry within the same cycle.
module pc_btb
  import pc_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  logic            valid_q  [BTB_ENTRIES];
  logic [TAGW-1:0] tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0] target_q [BTB_ENTRIES];
  ctr_e            ctr_q    [BTB_ENTRIES];

  logic [IDX-1:0]  rd_idx, wr_idx;
  logic [TAGW-1:0] rd_tag, wr_tag;
  logic            rd_hit, wr_hit;

  // Byte-offset bits never address the table.
  logic unused_offset;
  assign unused_offset = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign rd_idx = lookup_pc[IDX+1:2];
  assign rd_tag = lookup_pc[XLEN-1:IDX+2];
  assign wr_idx = upd_pc[IDX+1:2];
  assign wr_tag = upd_pc[XLEN-1:IDX+2];

  always_comb begin
    rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    wr_hit      = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    pred_taken  = rd_hit && ctr_q[rd_idx][1];
    pred_target = rd_hit ? target_q[rd_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (upd_en) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], upd_taken);
        if (upd_taken) target_q[wr_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= upd_target;
        ctr_q[wr_idx]    <= WT;
      end
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with BTB-based prediction, misprediction recovery/flush and
// saturating branch/mispredict statistics.
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            id_jump,
  input  logic [XLEN-1:0] id_jump_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pcvalue,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            flush,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  logic [XLEN-1:0] pcvalue_q, pc_d;
  logic [31:0]     branch_count_q, mispredict_count_q;
  logic            mispredict;

  pc_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .lookup_pc   (pcvalue_q),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_en      (ex_valid),
    .upd_pc      (ex_pc),
    .upd_taken   (ex_taken),
    .upd_target  (ex_target)
  );

  always_comb begin
    mispredict = 1'b0;
    if (!reset && ex_valid) begin
      mispredict = (ex_taken != ex_pred_taken) ||
                   (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));
    end
  end

  // Recovery outranks the stall: the stalled instruction is on the squashed path.
  always_comb begin
    pc_d = pcvalue_q + XLEN'(4);
    if (mispredict) begin
      pc_d = ex_taken ? ex_target : ex_pc + XLEN'(4);
    end else if (!pc_write) begin
      pc_d = pcvalue_q;
    end else if (id_jump) begin
      pc_d = id_jump_target;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcvalue_q          <= RESET_PC;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      pcvalue_q <= pc_d;
      if (ex_valid && (branch_count_q != '1)) branch_count_q <= branch_count_q + 32'd1;
      if (mispredict && (mispredict_count_q != '1)) begin
        mispredict_count_q <= mispredict_count_q + 32'd1;
      end
    end
  end

  assign pcvalue          = pcvalue_q;
  assign flush            = mispredict;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
